// File: rtl/axi_ar_fifo_reader.sv
// Purpose: pops 49-bit AR address packets from the read side of the CDC FIFO and drives them onto AXI AR.
// Latency: 1 cycle from a pop to ARVALID; back-to-back pops sustain one AR per cycle.
// Backpressure: ARREADY low holds the AR register and stops popping; committed bursts at MAX_OUTST stop popping.
module axi_ar_fifo_reader #(
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  // FIFO read side
  input  logic             fifo_not_empty,
  input  logic [48:0]      fifo_r_data,
  output logic             fifo_rd_en,
  // AXI AR channel
  output logic [7:0]       ARID,
  output logic [31:0]      ARADDR,
  output logic [3:0]       ARLEN,
  output logic [2:0]       ARSIZE,
  output logic [1:0]       ARBURST,
  output logic             ARVALID,
  input  logic             ARREADY,
  // AXI R channel, monitored only for burst retirement
  input  logic             RVALID,
  input  logic             RREADY,
  input  logic             RLAST,
  // status
  output logic [CNT_W-1:0] outstanding,
  output logic             idle
);

  // Packet layout as written by the FIFO's write side, MSB first.
  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_pkt_t;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  // committed can reach MAX_OUTST (up to 15) plus one held entry, hence one extra bit.
  localparam logic [CNT_W:0]   LIMIT   = (CNT_W+1)'(MAX_OUTST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  state_t           state;
  ar_pkt_t          ar_q;
  logic             ar_vld_q;
  logic [CNT_W-1:0] outst_q;

  ar_pkt_t          pkt_in;
  logic             ar_hs;
  logic             r_done;
  logic [CNT_W:0]   committed;
  logic             slot_free;
  logic             pop;

  assign pkt_in    = ar_pkt_t'(fifo_r_data);
  assign ar_hs     = ar_vld_q & ARREADY;
  assign r_done    = RVALID & RREADY & RLAST;

  // Held entry counts against the limit so the register never loads a burst we could not afford.
  assign committed = {1'b0, outst_q} + {{CNT_W{1'b0}}, ar_vld_q};
  assign slot_free = (committed < LIMIT);

  // r_done is intentionally left out: the R channel never reaches fifo_rd_en combinationally,
  // at the cost of one cycle of pop delay after a retirement at the limit.
  assign pop        = rstn & fifo_not_empty & (~ar_vld_q | ARREADY) & slot_free;
  assign fifo_rd_en = pop;

  // Holding register FSM: load on pop, reload on handshake+pop, drain on handshake alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_EMPTY;
      ar_vld_q <= 1'b0;
      ar_q     <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (pop) begin
            state    <= ST_LOADED;
            ar_vld_q <= 1'b1;
            ar_q     <= pkt_in;
          end
        end
        ST_LOADED: begin
          if (pop) begin
            // pop in LOADED implies ARREADY, so the current entry left this edge
            ar_q <= pkt_in;
          end else if (ar_hs) begin
            state    <= ST_EMPTY;
            ar_vld_q <= 1'b0;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          ar_vld_q <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding bursts: +1 per AR handshake, -1 per RLAST beat, saturating at both ends.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outst_q <= '0;
    end else begin
      case ({ar_hs, r_done})
        2'b10: if (outst_q != CNT_MAX) outst_q <= outst_q + CNT_W'(1);
        2'b01: if (outst_q != '0)      outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  assign ARID        = ar_q.id;
  assign ARADDR      = ar_q.addr;
  assign ARLEN       = ar_q.len;
  assign ARSIZE      = ar_q.size;
  assign ARBURST     = ar_q.burst;
  assign ARVALID     = ar_vld_q;
  assign outstanding = outst_q;
  assign idle        = ~ar_vld_q & (outst_q == '0) & ~fifo_not_empty;

  // Parameter legality: limit fits 1..15 and the counter can represent it.
  a_params: assert property (@(posedge clk)
    (MAX_OUTST >= 1) && (MAX_OUTST <= 15) && ((1 << CNT_W) > MAX_OUTST))
    else $error("axi_ar_fifo_reader: illegal MAX_OUTST/CNT_W");

  // RLAST with nothing outstanding means the slave returned a burst we never issued.
  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(r_done && (outst_q == '0)))
    else $error("axi_ar_fifo_reader: RLAST with no outstanding burst");

  // AXI requires the AR payload to stay put until accepted.
  a_ar_stable: assert property (@(posedge clk) disable iff (!rstn)
    (ar_vld_q && !ARREADY) |=> (ar_vld_q && $stable(ar_q)))
    else $error("axi_ar_fifo_reader: AR payload changed while stalled");

  // The limit gate on popping must keep the counter within range.
  a_outst_bound: assert property (@(posedge clk) disable iff (!rstn)
    outst_q <= CNT_MAX)
    else $error("axi_ar_fifo_reader: outstanding above limit");

endmodule

// File: tb/tb_axi_ar_fifo_reader.sv
// Bench for axi_ar_fifo_reader: queue-based FIFO, transaction-level expectation model,
// per-cycle comparison at the falling edge plus directed literal checks.
module tb_axi_ar_fifo_reader;

  localparam int MAX_OUTST = 4;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             fifo_not_empty = 1'b0;
  logic [48:0]      fifo_r_data = '0;
  logic             fifo_rd_en;
  logic [7:0]       ARID;
  logic [31:0]      ARADDR;
  logic [3:0]       ARLEN;
  logic [2:0]       ARSIZE;
  logic [1:0]       ARBURST;
  logic             ARVALID;
  logic             ARREADY = 1'b0;
  logic             RVALID = 1'b0;
  logic             RREADY = 1'b0;
  logic             RLAST = 1'b0;
  logic [CNT_W-1:0] outstanding;
  logic             idle;

  int n_cmp = 0;
  int n_bad = 0;

  logic [48:0] fifo_q[$];
  logic [48:0] hs_log[$];
  int          hs_cyc[$];
  int          n_hs = 0;
  int          cyc = 0;
  int          max_out = 0;

  // expectation model: one held entry plus a count of issued, unretired bursts
  logic        m_vld = 1'b0;
  logic [48:0] m_pkt = '0;
  int          m_out = 0;

  axi_ar_fifo_reader #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .fifo_not_empty(fifo_not_empty), .fifo_r_data(fifo_r_data), .fifo_rd_en(fifo_rd_en),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .outstanding(outstanding), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [48:0] mk_pkt(input logic [7:0] id, input logic [31:0] addr,
                                         input logic [3:0] len, input logic [2:0] size,
                                         input logic [1:0] burst);
    return {id, addr, len, size, burst};
  endfunction

  task automatic refresh_fifo();
    fifo_not_empty = (fifo_q.size() != 0);
    fifo_r_data    = fifo_not_empty ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [48:0] p);
    fifo_q.push_back(p);
    refresh_fifo();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_r(input logic v);
    RVALID = v;
    RREADY = v;
    RLAST  = v;
  endtask

  // Compare every cycle at the falling edge, then advance the model for the coming rising edge.
  initial begin : env
    logic exp_rd;
    logic exp_idle;
    logic pop_now;
    logic hs;
    logic rd;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        m_vld = 1'b0;
        m_pkt = '0;
        m_out = 0;
      end
      exp_rd   = rstn && fifo_not_empty && (!m_vld || ARREADY) && ((m_out + int'(m_vld)) < MAX_OUTST);
      exp_idle = !m_vld && (m_out == 0) && !fifo_not_empty;
      chk("cyc_rd_en",    64'(fifo_rd_en), 64'(exp_rd));
      chk("cyc_arvalid",  64'(ARVALID), 64'(m_vld));
      chk("cyc_fields",   64'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST}), 64'(m_pkt));
      chk("cyc_outst",    64'(outstanding), 64'(m_out));
      chk("cyc_idle",     64'(idle), 64'(exp_idle));
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      if (ARVALID && ARREADY) begin
        hs_log.push_back({ARID, ARADDR, ARLEN, ARSIZE, ARBURST});
        hs_cyc.push_back(cyc);
        n_hs++;
      end
      pop_now = fifo_rd_en && fifo_not_empty;
      if (rstn) begin
        hs = m_vld && ARREADY;
        rd = RVALID && RREADY && RLAST;
        if (hs && !rd) m_out++;
        else if (!hs && rd && m_out > 0) m_out--;
        if (exp_rd) begin
          m_vld = 1'b1;
          m_pkt = fifo_r_data;
        end else if (hs) begin
          m_vld = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      if (pop_now) begin
        void'(fifo_q.pop_front());
        refresh_fifo();
      end
    end
  end

  initial begin : main
    logic [48:0] pa, pb, pc, pf, pg, ph;
    logic [48:0] pd[6];
    logic [48:0] pe[8];
    int hs0;

    pa = mk_pkt(8'h3A, 32'h0001_0040, 4'd3, 3'd2, 2'b01);
    pb = mk_pkt(8'h11, 32'h0000_1000, 4'd0, 3'd2, 2'b01);
    pc = mk_pkt(8'h22, 32'h0000_2000, 4'd7, 3'd3, 2'b10);
    ph = mk_pkt(8'h60, 32'h0000_6000, 4'd0, 3'd0, 2'b00);
    pf = mk_pkt(8'h61, 32'h0000_6100, 4'd1, 3'd1, 2'b01);
    pg = mk_pkt(8'h62, 32'h0000_6200, 4'd2, 3'd2, 2'b10);
    for (int i = 0; i < 6; i++) pd[i] = mk_pkt(8'(8'h40 + i), 32'(32'h0003_0000 + i * 256), 4'd1, 3'd2, 2'b01);
    for (int i = 0; i < 8; i++) pe[i] = mk_pkt(8'(8'h50 + i), 32'(32'h2000_0000 + i * 64), 4'(i), 3'd3, 2'b01);

    // reset state
    #1 rstn = 1'b0;
    ticks(2);
    chk("rst_arvalid", 64'(ARVALID), 64'(0));
    chk("rst_outst",   64'(outstanding), 64'(0));
    chk("rst_rd_en",   64'(fifo_rd_en), 64'(0));
    chk("rst_idle",    64'(idle), 64'(1));
    chk("rst_fields",  64'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST}), 64'(0));
    rstn = 1'b1;
    #1;
    chk("rel_rd_en_empty", 64'(fifo_rd_en), 64'(0));
    tick();

    // single burst
    ARREADY = 1'b1;
    push(pa);
    tick();
    chk("t1_arvalid", 64'(ARVALID), 64'(1));
    chk("t1_arid",    64'(ARID), 64'(8'h3A));
    chk("t1_araddr",  64'(ARADDR), 64'(32'h0001_0040));
    chk("t1_arlen",   64'(ARLEN), 64'(3));
    chk("t1_arsize",  64'(ARSIZE), 64'(2));
    chk("t1_arburst", 64'(ARBURST), 64'(1));
    tick();
    chk("t1_drain_arvalid", 64'(ARVALID), 64'(0));
    chk("t1_outst1",        64'(outstanding), 64'(1));
    chk("t1_not_idle",      64'(idle), 64'(0));
    RVALID = 1'b1; RREADY = 1'b1; RLAST = 1'b0;
    ticks(3);
    chk("t1_outst_mid", 64'(outstanding), 64'(1));
    RLAST = 1'b1;
    tick();
    set_r(1'b0);
    chk("t1_outst0", 64'(outstanding), 64'(0));
    chk("t1_idle",   64'(idle), 64'(1));

    // backpressure
    ARREADY = 1'b0;
    push(pb);
    push(pc);
    tick();
    chk("t2_arvalid", 64'(ARVALID), 64'(1));
    chk("t2_arid",    64'(ARID), 64'(8'h11));
    repeat (5) begin
      chk("t2_hold_rd_en",  64'(fifo_rd_en), 64'(0));
      chk("t2_hold_araddr", 64'(ARADDR), 64'(32'h0000_1000));
      chk("t2_hold_arvld",  64'(ARVALID), 64'(1));
      tick();
    end
    ARREADY = 1'b1;
    #1;
    chk("t2_rd_en_release", 64'(fifo_rd_en), 64'(1));
    tick();
    chk("t2_second_arid",   64'(ARID), 64'(8'h22));
    chk("t2_second_arlen",  64'(ARLEN), 64'(7));
    chk("t2_second_arvld",  64'(ARVALID), 64'(1));
    chk("t2_outst1",        64'(outstanding), 64'(1));
    tick();
    chk("t2_drain_arvld", 64'(ARVALID), 64'(0));
    chk("t2_outst2",      64'(outstanding), 64'(2));
    set_r(1'b1);
    ticks(2);
    set_r(1'b0);
    chk("t2_outst0", 64'(outstanding), 64'(0));

    // outstanding limit
    hs0 = n_hs;
    for (int i = 0; i < 6; i++) push(pd[i]);
    ticks(8);
    chk("t3_hs4",        64'(n_hs - hs0), 64'(4));
    chk("t3_outst4",     64'(outstanding), 64'(4));
    chk("t3_rd_en0",     64'(fifo_rd_en), 64'(0));
    chk("t3_arvld0",     64'(ARVALID), 64'(0));
    chk("t3_fifo_level", 64'(fifo_q.size()), 64'(2));
    set_r(1'b1);
    tick();
    set_r(1'b0);
    #1;
    chk("t3_outst3",  64'(outstanding), 64'(3));
    chk("t3_rd_en1",  64'(fifo_rd_en), 64'(1));
    ticks(2);
    chk("t3_hs5",        64'(n_hs - hs0), 64'(5));
    chk("t3_outst4b",    64'(outstanding), 64'(4));
    chk("t3_rd_en0b",    64'(fifo_rd_en), 64'(0));

    // handshake and retirement on the same edge
    ARREADY = 1'b0;
    set_r(1'b1);
    tick();
    tick();
    set_r(1'b0);
    chk("t4_outst2",  64'(outstanding), 64'(2));
    chk("t4_arvld1",  64'(ARVALID), 64'(1));
    chk("t4_arid",    64'(ARID), 64'(8'h45));
    ARREADY = 1'b1;
    set_r(1'b1);
    tick();
    set_r(1'b0);
    chk("t4_simul_outst", 64'(outstanding), 64'(2));
    chk("t4_simul_arvld", 64'(ARVALID), 64'(0));
    set_r(1'b1);
    ticks(2);
    set_r(1'b0);
    chk("t4_outst0", 64'(outstanding), 64'(0));
    chk("t4_idle",   64'(idle), 64'(1));

    // streaming
    hs_log.delete();
    hs_cyc.delete();
    max_out = 0;
    hs0 = n_hs;
    for (int i = 0; i < 8; i++) push(pe[i]);
    for (int i = 0; i < 14; i++) begin
      set_r(m_out != 0);
      tick();
    end
    set_r(1'b0);
    chk("t5_hs8",      64'(n_hs - hs0), 64'(8));
    chk("t5_max_out",  64'(max_out), 64'(1));
    chk("t5_outst0",   64'(outstanding), 64'(0));
    chk("t5_idle",     64'(idle), 64'(1));
    if (hs_log.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("t5_order", 64'(hs_log[i]), 64'(pe[i]));
      chk("t5_span", 64'(hs_cyc[7] - hs_cyc[0]), 64'(7));
    end else begin
      chk("t5_log_size", 64'(hs_log.size()), 64'(8));
    end

    // reset while holding
    ARREADY = 1'b1;
    push(ph);
    push(pf);
    push(pg);
    tick();
    tick();
    ARREADY = 1'b0;
    chk("t6_arid_f",  64'(ARID), 64'(8'h61));
    chk("t6_outst1",  64'(outstanding), 64'(1));
    ticks(2);
    chk("t6_hold_arid",  64'(ARID), 64'(8'h61));
    chk("t6_hold_arvld", 64'(ARVALID), 64'(1));
    chk("t6_hold_rd_en", 64'(fifo_rd_en), 64'(0));
    rstn = 1'b0;
    ARREADY = 1'b1;
    #1;
    chk("t6_rst_arvld",  64'(ARVALID), 64'(0));
    chk("t6_rst_outst",  64'(outstanding), 64'(0));
    chk("t6_rst_fields", 64'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST}), 64'(0));
    chk("t6_rst_rd_en",  64'(fifo_rd_en), 64'(0));
    chk("t6_rst_idle",   64'(idle), 64'(0));
    tick();
    chk("t6_rst_rd_en2", 64'(fifo_rd_en), 64'(0));
    rstn = 1'b1;
    #1;
    chk("t6_rel_rd_en", 64'(fifo_rd_en), 64'(1));
    tick();
    chk("t6_g_arvld", 64'(ARVALID), 64'(1));
    chk("t6_g_arid",  64'(ARID), 64'(8'h62));
    tick();
    chk("t6_g_outst", 64'(outstanding), 64'(1));
    chk("t6_g_drain", 64'(ARVALID), 64'(0));
    set_r(1'b1);
    tick();
    set_r(1'b0);
    chk("t6_idle", 64'(idle), 64'(1));
    ticks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
